// File: rtl/vga_pkg.sv
// Shared FSM state encoding and default sizing for the data_interp upsampler.
package vga_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_UP     = 3;
  localparam int DEF_MAX_IN = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DIV   = 3'd2,
    ST_EMIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/data_interp_seq_div_u.sv
// Unsigned restoring divider by a constant: one quotient bit per cycle, W cycles
// after start, then a one-cycle done pulse. quot/rem hold until the next start.
module seq_div_u #(
  parameter int W       = 12,
  parameter int DIVISOR = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] DIV_W = W'(DIVISOR);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_sh;

  // quot doubles as the dividend shift register during the iteration
  assign rem_sh = {rem[W-2:0], quot[W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      quot <= '0;
      rem  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quot <= dividend;
        rem  <= '0;
        cnt  <= CW'(W);
        busy <= 1'b1;
      end else if (busy) begin
        if (rem_sh >= DIV_W) begin
          rem  <= rem_sh - DIV_W;
          quot <= {quot[W-2:0], 1'b1};
        end else begin
          rem  <= rem_sh;
          quot <= {quot[W-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_interp.sv
// Stream upsampler: UP outputs per input, linear interpolation between neighbours.
// Optional DATA_INTERP_HOLD_EN adds a per-sample sample-and-hold mode (hold_mode).
module data_interp
  import vga_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int UP     = DEF_UP,
  parameter int MAX_IN = DEF_MAX_IN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(MAX_IN*UP)-1:0]  out_idx,
  input  logic                          hold_mode
);

  localparam int IW = $clog2(MAX_IN * UP);
  localparam int KW = $clog2(UP + 1);
  localparam int CW = $clog2(MAX_IN + 1);
  localparam logic [KW-1:0]     K_LAST   = KW'(UP - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(MAX_IN - 1);
  localparam logic [DATA_W-1:0] UP_W     = DATA_W'(UP);

  state_t              state;
  logic [DATA_W-1:0]   a, b, acc, e;
  logic                b_last, neg;
  logic [KW-1:0]       k;
  logic [CW-1:0]       in_cnt;
  logic [DATA_W-1:0]   q, r, step_q, step_r;
  logic [DATA_W-1:0]   e_sum, e_next, acc_next, mag;
  logic [DATA_W:0]     diff;
  logic                div_done, div_start, carry;
  logic                in_hs, out_hs, last_eff, hold_skip;

  assign in_ready  = rst_n && (state == ST_IDLE || state == ST_FETCH);
  assign out_valid = (state == ST_EMIT) || (state == ST_HOLD);
  assign out_last  = (state == ST_HOLD) && (k == K_LAST);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_eff  = in_last || (in_cnt == CNT_LAST);

  assign diff = {1'b0, in_data} - {1'b0, a};
  assign mag  = diff[DATA_W] ? (~diff[DATA_W-1:0] + DATA_W'(1)) : diff[DATA_W-1:0];

`ifdef DATA_INTERP_HOLD_EN
  logic flat;
  assign hold_skip = hold_mode;
  assign step_q    = flat ? '0 : q;
  assign step_r    = flat ? '0 : r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flat <= 1'b0;
    else if (state == ST_FETCH && in_hs) flat <= hold_mode;
  end
`else
  logic unused_hold;
  assign unused_hold = hold_mode;
  assign hold_skip   = 1'b0;
  assign step_q      = q;
  assign step_r      = r;
`endif

  assign div_start = (state == ST_FETCH) && in_hs && !hold_skip;

  seq_div_u #(.W(DATA_W), .DIVISOR(UP)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (mag),
    .done     (div_done),
    .quot     (q),
    .rem      (r)
  );

  // acc = q*k + floor(r*k/UP), e = r*k mod UP, so acc tracks floor(|B-A|*k/UP)
  assign e_sum    = e + step_r;
  assign carry    = (e_sum >= UP_W);
  assign e_next   = carry ? (e_sum - UP_W) : e_sum;
  assign acc_next = acc + step_q + {{(DATA_W-1){1'b0}}, carry};

  always_comb begin
    out_data = '0;
    case (state)
      ST_EMIT: out_data = neg ? (a - acc) : (a + acc);
      ST_HOLD: out_data = a;
      default: out_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a      <= '0;
      b      <= '0;
      b_last <= 1'b0;
      neg    <= 1'b0;
      acc    <= '0;
      e      <= '0;
      k      <= '0;
      in_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_hs) begin
          a      <= in_data;
          k      <= '0;
          in_cnt <= CW'(1);
          state  <= last_eff ? ST_HOLD : ST_FETCH;
        end
        ST_FETCH: if (in_hs) begin
          b      <= in_data;
          b_last <= last_eff;
          neg    <= diff[DATA_W];
          in_cnt <= in_cnt + CW'(1);
          acc    <= '0;
          e      <= '0;
          k      <= '0;
          state  <= hold_skip ? ST_EMIT : ST_DIV;
        end
        ST_DIV: if (div_done) state <= ST_EMIT;
        ST_EMIT: if (out_hs) begin
          if (k == K_LAST) begin
            a     <= b;
            k     <= '0;
            acc   <= '0;
            e     <= '0;
            state <= b_last ? ST_HOLD : ST_FETCH;
          end else begin
            k   <= k + KW'(1);
            acc <= acc_next;
            e   <= e_next;
          end
        end
        ST_HOLD: if (out_hs) begin
          if (k == K_LAST) begin
            k      <= '0;
            in_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_idx <= '0;
    else if (out_hs) out_idx <= out_last ? '0 : out_idx + IW'(1);
  end

endmodule

// File: tb/tb_data_interp.sv
// Scoreboard bench for data_interp: a frame-level reference model queues expected
// outputs at issue time; an independent monitor pops and compares on each output handshake.
module tb_data_interp;

  localparam int DW   = 12;
  localparam int UPF  = 3;
  localparam int MAXN = 4;
  localparam int IW   = $clog2(MAXN * UPF);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, out_ready;
  logic [IW-1:0] out_idx;
  logic          hold_mode;

  always #5 clk = ~clk;

  data_interp #(.DATA_W(DW), .UP(UPF), .MAX_IN(MAXN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .hold_mode (hold_mode)
  );

  typedef struct { int d; bit last; int idx; } exp_t;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_script[$];

`ifdef DATA_INTERP_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: output k between A and B is A moved toward B by floor(|B-A|*k/UP)
  function automatic int interp(int a, int b, int k);
    if (b >= a) return a + ((b - a) * k) / UPF;
    return a - ((a - b) * k) / UPF;
  endfunction

  task automatic emit_frame(int fs[$], bit fh[$]);
    int n = fs.size();
    int pos = 0;
    for (int j = 0; j < n - 1; j++)
      for (int kk = 0; kk < UPF; kk++) begin
        exp_q.push_back('{(HOLD_EN && fh[j+1]) ? fs[j] : interp(fs[j], fs[j+1], kk), 1'b0, pos});
        pos++;
      end
    for (int kk = 0; kk < UPF; kk++) begin
      exp_q.push_back('{fs[n-1], kk == UPF - 1, pos});
      pos++;
    end
  endtask

  task automatic issue(int s[$], bit l[$], bit h[$]);
    int fs[$];
    bit fh[$];
    for (int i = 0; i < s.size(); i++) begin
      fs.push_back(s[i]);
      fh.push_back(h[i]);
      if (l[i] || fs.size() == MAXN) begin
        emit_frame(fs, fh);
        fs.delete();
        fh.delete();
      end
    end
  endtask

  task automatic send(int d, bit l, bit h);
    int n = 0;
    in_data   = d[DW-1:0];
    in_last   = l;
    hold_mode = h;
    in_valid  = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 500);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL input_accept: in_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_list(int s[$], bit l[$], bit h[$]);
    issue(s, l, h);
    for (int i = 0; i < s.size(); i++) begin
      if (rdy_rand) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      send(s[i], l[i], h[i]);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin @(posedge clk); n++; #1; end while (!out_valid && n < 200);
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL wait_out_valid: out_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic pair_lat(int a, int b, bit h, int lat);
    int s[$];
    bit l[$];
    bit hq[$];
    int n = 0;
    s = '{a, b}; l = '{1'b0, 1'b1}; hq = '{1'b0, h};
    issue(s, l, hq);
    send(a, 1'b0, 1'b0);
    send(b, 1'b1, h);
    do begin @(posedge clk); n++; #1; end while (!out_valid && n < 64);
    chk("first_out_latency", n, lat);
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return (1 << DW) - 1;
      default: return int'($urandom_range(0, (1 << DW) - 1));
    endcase
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rdy_script.size() > 0) out_ready = rdy_script.pop_front();
      else if (rdy_rand)         out_ready = ($urandom_range(0, 3) != 0);
      else                       out_ready = 1'b1;
    end
  end

  initial begin
    bit   stall = 1'b0;
    int   sd = 0;
    bit   sl = 1'b0;
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), sd);
          chk("stall_last", int'(out_last), int'(sl));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_output: got data %0d, required no output", out_data);
          end else begin
            x = exp_q.pop_front();
            chk("out_data", int'(out_data), x.d);
            chk("out_last", int'(out_last), int'(x.last));
            chk("out_idx", int'(out_idx), x.idx);
          end
        end
        stall = out_valid && !out_ready;
        sd    = int'(out_data);
        sl    = out_last;
      end
    end
  end

  initial begin
    int s[$];
    bit l[$];
    bit h[$];
    int n;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; hold_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("release_in_ready", int'(in_ready), 1);

    pair_lat(0, 3, 1'b0, DW + 1);
    s = '{10, 4}; l = '{0, 1}; h = '{0, 0}; send_list(s, l, h);
    s = '{5, 0};  l = '{0, 1}; h = '{0, 0}; send_list(s, l, h);

    // backpressure inside EMIT
    s = '{0, 9}; l = '{0, 1}; h = '{0, 0}; send_list(s, l, h);
    wait_valid();
    rdy_script = '{1'b1, 1'b0, 1'b0, 1'b1};

    // reset at k=1 of EMIT drops the frame
    s = '{20, 50}; l = '{0, 1}; h = '{0, 0}; send_list(s, l, h);
    n = 0;
    while (exp_q.size() > 6 && n < 500) begin @(posedge clk); n++; end
    #1 wait_valid();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_in_ready", int'(in_ready), 0);
    chk("midreset_out_idx", int'(out_idx), 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    s = '{7}; l = '{1}; h = '{0}; send_list(s, l, h);

    // MAX_IN forces the 4th sample to close the frame
    s = '{100, 40, 41, 4000, 2000, 2003}; l = '{0, 0, 0, 0, 0, 1}; h = '{0, 0, 0, 0, 0, 0};
    send_list(s, l, h);

`ifdef DATA_INTERP_HOLD_EN
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin @(posedge clk); n++; end
    #1 pair_lat(7, 9, 1'b1, 1);
`endif

    rdy_rand = 1'b1;
    for (int g = 0; g < 30; g++) begin
      int len = int'($urandom_range(1, 6));
      s.delete(); l.delete(); h.delete();
      for (int i = 0; i < len; i++) begin
        s.push_back(rnd_sample());
        l.push_back(i == len - 1);
        h.push_back($urandom_range(0, 1) == 1);
      end
      send_list(s, l, h);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin @(posedge clk); n++; end
    chk("drain_pending", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_interp.md
DATA_INTERP -- requirements
Module: data_interp

Interface
REQ-001 SHALL have parameter DATA_W, 12, sample width in bits.
REQ-002 SHALL have parameter UP, 3, output samples per input sample (integer 2..16).
REQ-003 SHALL have parameter MAX_IN, 256, maximum input samples per frame.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_data in DATA_W, in_valid in 1, in_last in 1, in_ready out 1: input sample stream.
REQ-007 SHALL have ports out_data out DATA_W, out_valid out 1, out_last out 1, out_ready in 1: output sample stream.
REQ-008 SHALL have port out_idx  out  $clog2(MAX_IN*UP)  index of current output within frame.
REQ-009 SHALL have port hold_mode  in  1  selects sample-and-hold instead of linear (see Configuration).

Function
REQ-010 SHALL transfer on a stream only when valid and ready are both high at a rising edge.
REQ-011 SHALL implement FSM IDLE, FETCH, DIV, EMIT, HOLD; in_ready high only in IDLE and FETCH.
REQ-012 IDLE: accepted sample -> register A; in_last high -> HOLD, else FETCH.
REQ-013 FETCH: accepted sample -> register B, flag B_last = in_last -> DIV.
REQ-014 DIV: unsigned restoring division |B-A| / UP giving q, r; lasts exactly DATA_W cycles, then EMIT.
REQ-015 EMIT: out_valid high; output k (k=0..UP-1) = A + sign(B-A)*floor(|B-A|*k/UP), generated Bresenham-style from q, r (no multiplier); A unchanged for k=0.
REQ-016 EMIT end (handshake of k=UP-1): A <= B; B_last -> HOLD, else FETCH.
REQ-017 HOLD: emit A exactly UP times; out_last high on the final one; then IDLE.
REQ-018 Frame output count SHALL be exactly N_in*UP; out_idx starts 0, increments per output handshake, returns to 0 after out_last.
REQ-019 out_data/out_valid/out_last SHALL hold stable while out_valid high and out_ready low.
REQ-020 B-accept edge to first out_valid SHALL be DATA_W+1 cycles; consecutive outputs at 1 per cycle with out_ready high.
REQ-021 Input sample number MAX_IN SHALL be treated as last regardless of in_last.
REQ-022 in_last on a frame's only sample SHALL produce UP copies of that sample.
REQ-023 Arithmetic SHALL use DATA_W+1-bit signed difference; outputs never leave [min(A,B), max(A,B)].

Reset
REQ-024 rst_n low SHALL force IDLE immediately, any cycle, including mid-DIV/EMIT; partial frame discarded.
REQ-025 Reset values: out_valid 0, out_last 0, out_data 0, out_idx 0, in_ready 0 while rst_n low, 1 on first cycle after release.

Configuration
REQ-026 Macro DATA_INTERP_HOLD_EN defined: hold_mode high SHALL skip DIV and emit A UP times per input (q=r=0 behaviour, zero DIV latency).
REQ-027 Macro undefined: hold_mode SHALL be ignored; linear interpolation only, no hold-mode logic synthesised.

Structure
REQ-028 FSM state enum and default DATA_W/UP/MAX_IN constants SHALL live in vga_pkg.
REQ-029 Divider SHALL be sub-module seq_div_u (start/done handshake, DATA_W-bit dividend, divisor UP).

Verification
REQ-030 Frame [0,3] last, UP=3 -> 0,1,2,3,3,3; out_last on 6th; out_idx 0..5.
REQ-031 Frame [10,4] last -> 10,8,6,4,4,4; frame [5,0] last -> 5,4,2,0,0,0 (floor on magnitude).
REQ-032 out_ready toggled 1-0-0-1 during EMIT -> no sample lost or duplicated; data stable while stalled.
REQ-033 rst_n pulsed low at k=1 of EMIT -> out_valid 0 in same cycle; next frame [7] last -> 7,7,7.
REQ-034 MAX_IN=4, five samples with in_last never set -> 12 outputs, out_last on 12th, fifth sample starts new frame.
REQ-035 With DATA_INTERP_HOLD_EN, hold_mode=1, frame [7,9] last -> 7,7,7,9,9,9; first out_valid 1 cycle after accept.
